// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and tx-queue dispatch state encoding
// Contents:
//   DefaultDepthLog2    default queue depth exponent (16 entries)
//   FMAX_MHz, BaudRate  UART clock/baud defaults shared with the rx/tx stages
//   txState_t           dispatch FSM states S_IDLE / S_WAIT_BUSY / S_WAIT_DONE
package uart_pkg;

  localparam int DefaultDepthLog2 = 4;
  localparam int FMAX_MHz         = 50;
  localparam int BaudRate         = 115200;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } txState_t;

endpackage

// File: rtl/sync_fifo_8.sv
// rtl/sync_fifo_8.sv - byte FIFO with occupancy, full/empty flags and sticky overflow
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wrEn, wrData        push request and byte (dropped while full)
//   rdEn                pop request (caller guarantees !empty)
//   rdData              byte at the read pointer (asynchronous read)
//   full, empty, level  registered occupancy state
//   overflow            sticky push-while-full flag
//   clrOverflow         clears overflow; a same-cycle overflow event wins
module sync_fifo_8
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [7:0]            wrData,
  input  logic                  rdEn,
  output logic [7:0]            rdData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clrOverflow
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthLevel = (DEPTH_LOG2 + 1)'(Depth);

  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  doPush;
  logic [DEPTH_LOG2:0]   levelNext;

  // Registered full gates the push, so a pop in the same cycle never makes room.
  assign doPush = wrEn && !full;
  assign rdData = mem[rdPtr];

  always_comb begin
    levelNext = level;
    if (doPush && !rdEn) begin
      levelNext = level + 1'b1;
    end else if (!doPush && rdEn) begin
      levelNext = level - 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (rdEn) begin
        rdPtr <= rdPtr + 1'b1;
      end
      level <= levelNext;
      full  <= (levelNext == DepthLevel);
      empty <= (levelNext == '0);
      if (wrEn && full) begin
        overflow <= 1'b1;
      end else if (clrOverflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue plus dispatch FSM feeding the UART transmitter
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   wr_en, wr_data             CPU-side push (ignored while full)
//   full, empty, level         queue occupancy
//   overflow, clr_overflow     sticky push-while-full flag and its clear
//   idle                       queue empty and no byte outstanding at the transmitter
//   tx_start, tx_data          one-cycle start pulse and byte to the transmitter
//   tx_ready                   transmitter ready (registered; lags start by one cycle)
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  idle,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);

  txState_t   state;
  txState_t   stateNext;
  logic [7:0] headByte;
  logic       issue;

  sync_fifo_8 #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uFifo (
    .clk         (clk),
    .reset       (reset),
    .wrEn        (wr_en),
    .wrData      (wr_data),
    .rdEn        (issue),
    .rdData      (headByte),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .clrOverflow (clr_overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // WAIT_BUSY waits for ready to fall before WAIT_DONE waits for it to rise,
  // because the transmitter's ready is still high in the cycle after start.
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:      if (issue)     stateNext = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_ready) stateNext = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_ready)  stateNext = S_IDLE;
      default:                    stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    issue = (state == S_IDLE) && !empty && tx_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= issue;
      if (issue) begin
        tx_data <= headByte;
      end
    end
  end

  assign idle = empty && (state == S_IDLE);

endmodule
